i2s_tdm_transmitter: RTL and testbench
======================================

# i2s_tdm_transmitter

Parametrised I2S/TDM serial audio transmitter: it accepts one frame of NCH samples per valid/ready handshake and serialises them MSB first onto SCLK/WS/SD. SCLK is generated internally from the system clock. It supports standard I2S (one-bit delay) and left-justified framing, and reports underruns. It is the multi-channel successor of the two-channel, fixed-format I2S transmitter and sits between the audio sample source and the pad-level I2S outputs.

## Interface
- DWIDTH, 16: sample width in bits.
- SWIDTH, 16: slot width in SCLK bits. SWIDTH ≥ DWIDTH; unused LSBs transmit 0.
- NCH, 2: channels per frame. Even, 2..8.
- CLK_DIV, 4: clk cycles per SCLK period. Even, ≥ 2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  NCH*DWIDTH  one frame of samples; channel k is tx_data[k*DWIDTH +: DWIDTH].
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register is empty; transfer occurs when tx_valid && tx_ready.
- enable  in  1  run the serial interface.
- mode  in  1  0 = I2S (SD delayed one SCLK after WS), 1 = left-justified.
- underrun  out  1  one-clk pulse when a frame starts with no data held.
- SCLK  out  1  bit clock.
- WS  out  1  word select.
- SD  out  1  serial data.

## Operation
- Reset values: SCLK=0, WS=0, SD=0, tx_ready=1, underrun=0. Holding register is empty; all counters are 0. All outputs are registered.
- Holding register is one frame deep.
  - Accept sets it full and drives tx_ready=0 on the next clk.
  - A frame load empties it and drives tx_ready=1 on the next clk.
- Divider: div_cnt counts 0..CLK_DIV-1 while enable=1.
  - A fall event occurs on the first clk edge with enable sampled high, then every CLK_DIV clks.
  - SCLK goes 0 at each fall event and goes 1 CLK_DIV/2 clks later.
- Bit counter b runs 0..NCH*SWIDTH-1, advances on each fall event, and wraps to 0.
- At each fall event, WS is updated to (b ≥ NCH*SWIDTH/2), using the new value of b.
  - Slots 0..NCH/2-1 are in the WS=0 half; the remaining slots are in the WS=1 half.
- Frame load happens at the fall event with b=0.
  - Holding register full: its contents go to the shift register.
  - Holding register empty: the shift register loads all zeros and underrun pulses for exactly that clk.
  - mode is sampled only at frame load and applies to the whole frame.
- Stream order: slot 0..NCH-1. Each slot carries its DWIDTH data bits MSB first, then SWIDTH-DWIDTH zeros.
- Left-justified mode: at count b, SD = stream bit b, so the MSB aligns with the WS transition.
- I2S mode: at count b, SD = stream bit b-1.
  - At b=0, SD = the last bit of the previous frame.
  - On the first frame after enable, that bit is 0.
- An accept in the same clk as a frame load with an empty holding register still counts as an underrun. The accepted frame waits for the next frame load.
- enable dropping mid-frame:
  - On the next clk: SCLK/WS/SD are 0, div_cnt=0, b=0, and the partial frame and I2S delay bit are discarded.
  - The holding register and tx_ready are kept.
  - Re-enable starts a new frame at b=0.
- rst_n asserted mid-operation: everything returns to its reset value immediately (asynchronously).

## Timing
- One SCLK bit lasts CLK_DIV clks. One frame lasts NCH*SWIDTH*CLK_DIV clks (defaults: 32 bits, 128 clks).
- SD and WS change only at fall events, so they are stable for CLK_DIV/2 clks before each SCLK rising edge.
- Accept-to-transmit latency:
  - Minimum: 1 clk, to the next frame load.
  - Maximum: one full frame.
- Sustained throughput: one frame per NCH*SWIDTH SCLKs. Continuous tx_valid produces no underrun after the first frame.
- tx_ready is 0 from the clk after an accept until the clk after the next frame load.

## Test plan
- Defaults, mode=1, enable=1, tx_data=32'hA5C3_1234 held valid.
  - Required: WS=0 for 16 bits carrying 0x1234 MSB first, then WS=1 for 16 bits carrying 0xA5C3.
  - A receiver sampling on SCLK rising edges recovers 0xA5C31234.
- Same stimulus with mode=0.
  - Required: first SD bit of the frame is 0; 0x1234 appears delayed one SCLK after WS falls.
  - The last bit of 0xA5C3 (1) appears at b=0 of the next frame.
- Enable with no tx_valid.
  - Required: underrun pulses once per frame (every 128 clks) and SD stays 0.
  - WS keeps toggling every 64 clks.
- NCH=4, SWIDTH=24, DWIDTH=16, tx_data={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}.
  - Required: WS=0 over slots AAAA and BBBB, WS=1 over CCCC and DDDD.
  - Each slot is followed by 8 zero bits; frame is 96 SCLKs.
- 64 random frames pushed back-to-back with tx_valid held.
  - Required: underrun only on the first frame, if unaligned.
  - All frames are recovered in order with 0 mismatches; tx_ready is never high while the holding register is full.
- Reset and enable interruptions.
  - Assert rst_n=0 mid-slot: all outputs are 0 immediately and tx_ready=1.
  - Separately, drop enable mid-frame with a frame held: the next clk has SCLK=WS=SD=0 and tx_ready=0. On re-enable, the held frame is sent from slot 0.

Source files
------------

// File: rtl/i2s_tdm_transmitter.sv
// i2s_tdm_transmitter: multi-channel I2S / left-justified TDM serialiser.
// Accepts one frame of NCH samples per valid/ready handshake into a one-deep
// holding register, then shifts the frame out MSB first on SCLK/WS/SD.
// SCLK is divided down from clk; SD and WS only change on SCLK fall events.
//
// state   | meaning
// S_IDLE  | serial interface stopped or just enabled; next fall event starts a frame at b=0
// S_RUN   | frame in progress; each fall event advances the bit counter
module i2s_tdm_transmitter #(
  parameter int DWIDTH  = 16,
  parameter int SWIDTH  = 16,
  parameter int NCH     = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH*DWIDTH-1:0]   tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic                    enable,
  input  logic                    mode,
  output logic                    underrun,
  output logic                    SCLK,
  output logic                    WS,
  output logic                    SD
);

  localparam int TOT  = NCH * SWIDTH;
  localparam int HALF = TOT / 2;
  localparam int BW   = $clog2(TOT);
  localparam int DW   = $clog2(CLK_DIV);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  r_state;
  logic [DW-1:0]           r_div;
  logic [BW-1:0]           r_bit;
  logic                    r_full;
  logic                    r_ready;
  logic [NCH*DWIDTH-1:0]   r_hold;
  logic [TOT-1:0]          r_sh;
  logic                    r_prev;
  logic                    r_mode;
  logic                    r_underrun;
  logic                    r_sclk;
  logic                    r_ws;
  logic                    r_sd;

  logic                    w_fall;
  logic [BW-1:0]           w_bit_nxt;
  logic                    w_load;
  logic                    w_accept;
  logic [NCH*DWIDTH-1:0]   w_src;
  logic [TOT-1:0]          w_frame;
  logic [SWIDTH-1:0]       w_slot;
  logic                    w_out_bit;
  logic [TOT-1:0]          w_sh_nxt;
  logic                    w_mode_cur;

  assign w_fall    = enable && (r_div == '0);
  assign w_accept  = tx_valid && r_ready;
  assign w_src     = r_full ? r_hold : '0;

  // Bit counter value after this fall event; a fresh frame always begins at 0.
  always_comb begin
    w_bit_nxt = '0;
    if (r_state == S_RUN && r_bit != BW'(TOT - 1)) begin
      w_bit_nxt = r_bit + 1'b1;
    end
  end

  assign w_load = w_fall && (w_bit_nxt == '0);

  // Lay the held samples out as the serial stream: slot 0 in the top bits,
  // each slot MSB first with its unused LSBs zero-filled.
  always_comb begin
    w_frame = '0;
    w_slot  = '0;
    for (int k = 0; k < NCH; k++) begin
      w_slot = '0;
      w_slot[SWIDTH-1 -: DWIDTH] = w_src[k*DWIDTH +: DWIDTH];
      w_frame[TOT-1-k*SWIDTH -: SWIDTH] = w_slot;
    end
  end

  assign w_out_bit  = w_load ? w_frame[TOT-1] : r_sh[TOT-1];
  assign w_sh_nxt   = w_load ? (w_frame << 1) : (r_sh << 1);
  assign w_mode_cur = w_load ? mode : r_mode;

  // Holding register handshake and underrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= 1'b0;
      r_ready    <= 1'b1;
      r_hold     <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load && !r_full;
      // An accept can only happen while empty, so it never races a full load.
      if (w_accept) begin
        r_hold  <= tx_data;
        r_full  <= 1'b1;
        r_ready <= 1'b0;
      end else if (w_load && r_full) begin
        r_full  <= 1'b0;
        r_ready <= 1'b1;
      end
    end
  end

  // SCLK divider, bit counter and serial output state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_prev  <= 1'b0;
      r_mode  <= 1'b0;
      r_sclk  <= 1'b0;
      r_ws    <= 1'b0;
      r_sd    <= 1'b0;
    end else if (!enable) begin
      // Stopping discards the partial frame and the I2S delay bit.
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_prev  <= 1'b0;
      r_sclk  <= 1'b0;
      r_ws    <= 1'b0;
      r_sd    <= 1'b0;
    end else begin
      r_div <= (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
      if (w_fall) begin
        r_state <= S_RUN;
        r_bit   <= w_bit_nxt;
        r_ws    <= (w_bit_nxt >= BW'(HALF));
        r_sclk  <= 1'b0;
        r_sh    <= w_sh_nxt;
        r_prev  <= w_out_bit;
        // I2S mode emits the previous stream bit, giving the one-SCLK delay.
        r_sd    <= w_mode_cur ? w_out_bit : r_prev;
        if (w_load) begin
          r_mode <= mode;
        end
      end else if (r_div == DW'(CLK_DIV / 2)) begin
        r_sclk <= 1'b1;
      end
    end
  end

  assign tx_ready = r_ready;
  assign underrun = r_underrun;
  assign SCLK     = r_sclk;
  assign WS       = r_ws;
  assign SD       = r_sd;

endmodule

// File: tb/tb_i2s_tdm_transmitter.sv
// Directed bench for i2s_tdm_transmitter: default 2-channel instance plus a
// 4-channel / 24-bit-slot instance, with a simple SCLK-rising-edge receiver.
module tb_i2s_tdm_transmitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b1;

  logic [31:0] data2 = '0;
  logic        valid2 = 1'b0;
  logic        ready2, ur2, sclk2, ws2, sd2;

  logic [63:0] data4 = '0;
  logic        valid4 = 1'b0;
  logic        ready4, ur4, sclk4, ws4, sd4;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  bit           sel4 = 1'b0;
  logic [127:0] cap, capws;
  int           n_ur, ur_first, ur_last;
  logic         sd_or;
  logic [31:0]  exp_q[$];
  int           n_acc, ready_viol, mism, frames_chk;

  wire sclk_m = sel4 ? sclk4 : sclk2;
  wire ws_m   = sel4 ? ws4   : ws2;
  wire sd_m   = sel4 ? sd4   : sd2;
  wire ur_m   = sel4 ? ur4   : ur2;

  always #5 clk = ~clk;

  i2s_tdm_transmitter u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
    .enable(enable), .mode(mode), .underrun(ur2), .SCLK(sclk2), .WS(ws2), .SD(sd2)
  );

  i2s_tdm_transmitter #(.DWIDTH(16), .SWIDTH(24), .NCH(4), .CLK_DIV(4)) u4 (
    .clk(clk), .rst_n(rst_n), .tx_data(data4), .tx_valid(valid4), .tx_ready(ready4),
    .enable(enable), .mode(mode), .underrun(ur4), .SCLK(sclk4), .WS(ws4), .SD(sd4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Receiver: collects SD/WS on each SCLK rise; optionally feeds u2 with
  // random frames and checks each recovered 32-bit frame against the queue.
  task automatic capture(input int nbits, input int budget, input bit feed);
    int   got = 0;
    int   n = 0;
    logic prev;
    logic acc;
    logic [31:0] w, rxf, e;
    cap = '0; capws = '0; n_ur = 0; ur_first = -1; ur_last = -1; sd_or = 1'b0;
    prev = sclk_m;
    while (got < nbits && n < budget) begin
      acc = feed && valid2 && ready2;
      tick();
      n++;
      if (acc) begin
        exp_q.push_back(data2);
        n_acc++;
        if (ready2) ready_viol++;
        if (n_acc == 64) valid2 = 1'b0;
        else data2 = $urandom;
      end
      if (ur_m) begin
        n_ur++;
        if (ur_first < 0) ur_first = cyc;
        ur_last = cyc;
      end
      if (sclk_m && !prev) begin
        cap   = {cap[126:0], sd_m};
        capws = {capws[126:0], ws_m};
        sd_or = sd_or | sd_m;
        got++;
        if (feed && (got % 32 == 0) && (got / 32 >= 2)) begin
          w   = cap[31:0];
          rxf = {w[15:0], w[31:16]};
          e   = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
          if (rxf !== e) mism++;
          frames_chk++;
        end
      end
      prev = sclk_m;
    end
    chk("capture_complete", got, nbits);
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", ready2, 1'b1);
    chk("rst_sclk", sclk2, 1'b0);
    chk("rst_ws", ws2, 1'b0);
    chk("rst_sd", sd2, 1'b0);
    chk("rst_underrun", ur2, 1'b0);

    // Left-justified frame
    mode = 1'b1;
    data2 = 32'hA5C3_1234; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    chk("lj_ready_after_accept", ready2, 1'b0);
    enable = 1'b1;
    capture(32, 32*4 + 16, 1'b0);
    chk("lj_frame", {cap[15:0], cap[31:16]}, 32'hA5C3_1234);
    chk("lj_ws", capws[31:0], 32'h0000_FFFF);
    chk("lj_underrun", n_ur, 0);
    chk("lj_ready_after_load", ready2, 1'b1);
    chk("lj_ws_before_drop", ws2, 1'b1);
    enable = 1'b0;
    tick();
    chk("drop_ws", ws2, 1'b0);
    chk("drop_sclk", sclk2, 1'b0);

    // I2S frame
    mode = 1'b0;
    data2 = 32'hA5C3_1234; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    enable = 1'b1;
    capture(33, 33*4 + 16, 1'b0);
    chk("i2s_stream", cap[32:0], 33'h0_1234_A5C3);
    chk("i2s_ws", capws[32:0], 33'h0_0001_FFFE);
    chk("i2s_underrun_next", n_ur, 1);
    enable = 1'b0;
    tick();

    // Enabled with no data: underrun every frame, SD silent
    mode = 1'b1;
    enable = 1'b1;
    capture(96, 96*4 + 16, 1'b0);
    chk("idle_underruns", n_ur, 3);
    chk("idle_ur_period", ur_last - ur_first, 256);
    chk("idle_sd_zero", sd_or, 1'b0);
    chk("idle_ws", capws[31:0], 32'h0000_FFFF);
    enable = 1'b0;
    tick();

    // 4 channels, 24-bit slots
    sel4 = 1'b1;
    data4 = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}; valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    chk("tdm_ready_after_accept", ready4, 1'b0);
    enable = 1'b1;
    capture(96, 96*4 + 16, 1'b0);
    chk("tdm_stream", cap[95:0], 96'hAAAA00_BBBB00_CCCC00_DDDD00);
    chk("tdm_ws", capws[95:0], 96'h000000_000000_FFFFFF_FFFFFF);
    chk("tdm_underrun", n_ur, 0);
    enable = 1'b0;
    tick();
    sel4 = 1'b0;

    // 64 back-to-back random frames, tx_valid held
    n_acc = 0; ready_viol = 0; mism = 0; frames_chk = 0;
    data2 = $urandom; valid2 = 1'b1; enable = 1'b1;
    capture(65*32, 65*32*4 + 40, 1'b1);
    chk("stream_accepts", n_acc, 64);
    chk("stream_frames", frames_chk, 64);
    chk("stream_mismatches", mism, 0);
    chk("stream_ready_viol", ready_viol, 0);
    chk("stream_underruns", n_ur, 1);
    valid2 = 1'b0;
    enable = 1'b0;
    tick();

    // Asynchronous reset mid-slot
    data2 = 32'h1357_9BDF; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    enable = 1'b1;
    tick();
    data2 = 32'h2468_ACE0; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    repeat (68) tick();
    chk("pre_rst_ws", ws2, 1'b1);
    chk("pre_rst_ready", ready2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ws", ws2, 1'b0);
    chk("async_rst_sclk", sclk2, 1'b0);
    chk("async_rst_sd", sd2, 1'b0);
    chk("async_rst_ready", ready2, 1'b1);
    chk("async_rst_underrun", ur2, 1'b0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Enable dropped mid-frame with a frame held, then resumed
    mode = 1'b1;
    data2 = 32'h1111_2222; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    enable = 1'b1;
    tick();
    data2 = 32'h0F0F_5A5A; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    repeat (68) tick();
    chk("hold_ws_before_drop", ws2, 1'b1);
    chk("hold_ready_before_drop", ready2, 1'b0);
    enable = 1'b0;
    tick();
    chk("hold_drop_sclk", sclk2, 1'b0);
    chk("hold_drop_ws", ws2, 1'b0);
    chk("hold_drop_sd", sd2, 1'b0);
    chk("hold_drop_ready", ready2, 1'b0);
    enable = 1'b1;
    capture(32, 32*4 + 16, 1'b0);
    chk("resume_frame", cap[31:0], 32'h5A5A_0F0F);
    chk("resume_ws", capws[31:0], 32'h0000_FFFF);
    chk("resume_underrun", n_ur, 0);
    enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
